// File: rtl/rv_bpu.sv
// rv_bpu: direct-mapped BTB plus a bimodal/gshare BHT of saturating counters.
// Zero-latency lookup from IF; EX resolutions train the tables and raise a registered redirect.
module rv_bpu #(
  parameter int XLEN  = 64,
  parameter int IDX_W = 6,
  parameter int CNT_W = 2,
  parameter int TAG_W = 8,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid_i,
  input  logic             if_stall_i,
  input  logic [XLEN-1:0]  if_pc_i,
  output logic             pred_taken_o,
  output logic [XLEN-1:0]  pred_target_o,
  output logic [IDX_W-1:0] pred_idx_o,
  output logic [IDX_W-1:0] pred_ghr_o,
  input  logic             upd_valid_i,
  input  logic [XLEN-1:0]  upd_pc_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic [IDX_W-1:0] upd_ghr_i,
  input  logic             upd_is_br_i,
  input  logic             upd_is_jmp_i,
  input  logic             upd_taken_i,
  input  logic [XLEN-1:0]  upd_target_i,
  input  logic             upd_pred_taken_i,
  input  logic [XLEN-1:0]  upd_pred_target_i,
  output logic             mispredict_o,
  output logic [XLEN-1:0]  redirect_pc_o
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(4);

  logic             btb_valid  [ENTRIES];
  logic [TAG_W-1:0] btb_tag    [ENTRIES];
  logic [XLEN-1:0]  btb_target [ENTRIES];
  logic             btb_jmp    [ENTRIES];
  logic [CNT_W-1:0] cnt        [ENTRIES];
  logic [IDX_W-1:0] ghr;

  logic [IDX_W-1:0] bidx;
  logic [IDX_W-1:0] bht_idx;
  logic [IDX_W-1:0] upd_bidx;
  logic [TAG_W-1:0] tag;
  logic [TAG_W-1:0] upd_tag;
  logic             hit;
  logic             taken;
  logic             spec_shift;
  logic             alloc;
  logic             mis;
  logic [XLEN-1:0]  actual;
  logic [XLEN-1:0]  predicted;

  assign bidx     = if_pc_i[IDX_W+1:2];
  assign tag      = if_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_bidx = upd_pc_i[IDX_W+1:2];
  assign upd_tag  = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign bht_idx  = (MODE == 1) ? (bidx ^ ghr) : bidx;

  assign hit           = btb_valid[bidx] && (btb_tag[bidx] == tag);
  assign taken         = hit && (btb_jmp[bidx] || cnt[bht_idx][CNT_W-1]);
  assign pred_taken_o  = taken;
  assign pred_target_o = taken ? btb_target[bidx] : if_pc_i + PC_STEP;
  assign pred_idx_o    = bht_idx;
  assign pred_ghr_o    = ghr;

  // Only conditional branches that hit in the BTB shift history speculatively.
  assign spec_shift = if_valid_i && !if_stall_i && hit && !btb_jmp[bidx];

  assign alloc     = upd_valid_i && ((upd_is_br_i && upd_taken_i) || upd_is_jmp_i);
  assign actual    = upd_taken_i ? upd_target_i : upd_pc_i + PC_STEP;
  assign predicted = upd_pred_taken_i ? upd_pred_target_i : upd_pc_i + PC_STEP;
  assign mis       = upd_valid_i && (actual != predicted);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        cnt[i]       <= CNT_INIT;
      end
    end else if (upd_valid_i) begin
      if (upd_is_br_i) begin
        if (upd_taken_i && (cnt[upd_idx_i] != CNT_MAX))
          cnt[upd_idx_i] <= cnt[upd_idx_i] + 1'b1;
        else if (!upd_taken_i && (cnt[upd_idx_i] != '0))
          cnt[upd_idx_i] <= cnt[upd_idx_i] - 1'b1;
      end
      if (alloc)
        btb_valid[upd_bidx] <= 1'b1;
    end
  end

  // Payload fields are qualified by the valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (!rst && alloc) begin
      btb_tag[upd_bidx]    <= upd_tag;
      btb_target[upd_bidx] <= upd_target_i;
      btb_jmp[upd_bidx]    <= upd_is_jmp_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr           <= '0;
      mispredict_o  <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      mispredict_o <= mis;
      if (mis)
        redirect_pc_o <= actual;
      if (MODE == 1) begin
        if (mis)
          ghr <= upd_is_br_i ? {upd_ghr_i[IDX_W-2:0], upd_taken_i} : upd_ghr_i;
        else if (spec_shift)
          ghr <= {ghr[IDX_W-2:0], taken};
      end
    end
  end

endmodule

// File: tb/tb_rv_bpu.sv
// tb_rv_bpu: directed scoreboard bench for rv_bpu, one bimodal and one gshare instance
// sharing the same stimulus.
module tb_rv_bpu;
  localparam int XLEN  = 64;
  localparam int IDX_W = 6;

  localparam int P0_TAKEN  = 0;
  localparam int P0_TARGET = 1;
  localparam int P0_MIS    = 2;
  localparam int P0_REDIR  = 3;
  localparam int P0_IDX    = 4;
  localparam int P0_GHR    = 5;
  localparam int P1_TAKEN  = 6;
  localparam int P1_TARGET = 7;
  localparam int P1_MIS    = 8;
  localparam int P1_IDX    = 9;
  localparam int P1_GHR    = 10;
  localparam int P1_REDIR  = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             if_valid;
  logic             if_stall;
  logic [XLEN-1:0]  if_pc;
  logic             upd_valid;
  logic [XLEN-1:0]  upd_pc;
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] upd_ghr;
  logic             upd_is_br;
  logic             upd_is_jmp;
  logic             upd_taken;
  logic [XLEN-1:0]  upd_target;
  logic             upd_pred_taken;
  logic [XLEN-1:0]  upd_pred_target;

  logic             p0_taken, p1_taken;
  logic [XLEN-1:0]  p0_target, p1_target;
  logic [IDX_W-1:0] p0_idx, p1_idx;
  logic [IDX_W-1:0] p0_ghr, p1_ghr;
  logic             p0_mis, p1_mis;
  logic [XLEN-1:0]  p0_redirect, p1_redirect;

  rv_bpu #(.XLEN(XLEN), .IDX_W(IDX_W), .CNT_W(2), .TAG_W(8), .MODE(0)) dut0 (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid), .if_stall_i(if_stall), .if_pc_i(if_pc),
    .pred_taken_o(p0_taken), .pred_target_o(p0_target),
    .pred_idx_o(p0_idx), .pred_ghr_o(p0_ghr),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_idx_i(upd_idx), .upd_ghr_i(upd_ghr),
    .upd_is_br_i(upd_is_br), .upd_is_jmp_i(upd_is_jmp), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
    .upd_pred_target_i(upd_pred_target),
    .mispredict_o(p0_mis), .redirect_pc_o(p0_redirect)
  );

  rv_bpu #(.XLEN(XLEN), .IDX_W(IDX_W), .CNT_W(2), .TAG_W(8), .MODE(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid), .if_stall_i(if_stall), .if_pc_i(if_pc),
    .pred_taken_o(p1_taken), .pred_target_o(p1_target),
    .pred_idx_o(p1_idx), .pred_ghr_o(p1_ghr),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_idx_i(upd_idx), .upd_ghr_i(upd_ghr),
    .upd_is_br_i(upd_is_br), .upd_is_jmp_i(upd_is_jmp), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
    .upd_pred_target_i(upd_pred_target),
    .mispredict_o(p1_mis), .redirect_pc_o(p1_redirect)
  );

  typedef struct {
    string           name;
    int              sel;
    logic [XLEN-1:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [XLEN-1:0] observe(input int sel);
    case (sel)
      P0_TAKEN:  observe = XLEN'(p0_taken);
      P0_TARGET: observe = p0_target;
      P0_MIS:    observe = XLEN'(p0_mis);
      P0_REDIR:  observe = p0_redirect;
      P0_IDX:    observe = XLEN'(p0_idx);
      P0_GHR:    observe = XLEN'(p0_ghr);
      P1_TAKEN:  observe = XLEN'(p1_taken);
      P1_TARGET: observe = p1_target;
      P1_MIS:    observe = XLEN'(p1_mis);
      P1_IDX:    observe = XLEN'(p1_idx);
      P1_GHR:    observe = XLEN'(p1_ghr);
      P1_REDIR:  observe = p1_redirect;
      default:   observe = 'x;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] bidx_of(input logic [XLEN-1:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  task automatic expect_val(input string name, input int sel, input logic [XLEN-1:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic check_output();
    exp_t e;
    logic [XLEN-1:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      tests++;
      assert (obs === e.exp)
      else begin
        fails++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic drive_lookup(input logic valid, input logic [XLEN-1:0] pc);
    if_valid = valid;
    if_pc    = pc;
  endtask

  task automatic drive_update(input logic valid, input logic [XLEN-1:0] pc,
                              input logic br, input logic jmp, input logic tk,
                              input logic [XLEN-1:0] tgt, input logic ptk,
                              input logic [XLEN-1:0] ptgt,
                              input logic [IDX_W-1:0] idx, input logic [IDX_W-1:0] ghr);
    upd_valid       = valid;
    upd_pc          = pc;
    upd_is_br       = br;
    upd_is_jmp      = jmp;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
    upd_idx         = idx;
    upd_ghr         = ghr;
  endtask

  task automatic idle_update();
    drive_update(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  // Branch resolution against dut0 at a given PC.
  task automatic resolve0(input logic [XLEN-1:0] pc, input logic jmp, input logic tk,
                          input logic [XLEN-1:0] tgt, input logic ptk,
                          input logic [XLEN-1:0] ptgt);
    drive_update(1'b1, pc, !jmp, jmp, tk, tgt, ptk, ptgt, bidx_of(pc), '0);
  endtask

  task automatic settle();
    #1;
    check_output();
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    check_output();
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0)
      assert (!(upd_is_br && upd_is_jmp))
      else $error("[TB] FAIL illegal_br_jmp: observed br=%0b jmp=%0b", upd_is_br, upd_is_jmp);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  logic             it_tk;
  logic [IDX_W-1:0] cap_idx;
  logic [IDX_W-1:0] cap_ghr;
  logic             cap_tk;
  logic [XLEN-1:0]  cap_tgt;

  initial begin
    rst      = 1'b1;
    if_stall = 1'b0;
    drive_lookup(1'b0, '0);
    idle_update();
    @(negedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    drive_lookup(1'b1, 64'h100);
    expect_val("rst_taken", P0_TAKEN, 0);
    expect_val("rst_target", P0_TARGET, 64'h104);
    expect_val("rst_idx", P0_IDX, 0);
    expect_val("rst_mis", P0_MIS, 0);
    expect_val("rst_redirect", P0_REDIR, 0);
    settle();

    // Cold taken branch at 0x200 -> 0x180
    drive_lookup(1'b0, '0);
    resolve0(64'h200, 1'b0, 1'b1, 64'h180, 1'b0, 64'h204);
    expect_val("cold_mis", P0_MIS, 1);
    expect_val("cold_redirect", P0_REDIR, 64'h180);
    cycle();
    idle_update();
    drive_lookup(1'b1, 64'h200);
    expect_val("cold_hit_taken", P0_TAKEN, 1);
    expect_val("cold_hit_target", P0_TARGET, 64'h180);
    settle();
    expect_val("mis_drop", P0_MIS, 0);
    cycle();

    // Upper saturation: six more taken resolutions keep the counter at 3
    for (int i = 0; i < 6; i++) begin
      resolve0(64'h200, 1'b0, 1'b1, 64'h180, 1'b1, 64'h180);
      expect_val("sat_up_mis", P0_MIS, 0);
      cycle();
    end
    resolve0(64'h200, 1'b0, 1'b0, 64'h180, 1'b1, 64'h180);
    expect_val("nt1_mis", P0_MIS, 1);
    expect_val("nt1_redirect", P0_REDIR, 64'h204);
    cycle();
    idle_update();
    expect_val("nt1_taken", P0_TAKEN, 1);
    expect_val("nt1_target", P0_TARGET, 64'h180);
    settle();
    resolve0(64'h200, 1'b0, 1'b0, 64'h180, 1'b1, 64'h180);
    cycle();
    idle_update();
    expect_val("nt2_taken", P0_TAKEN, 0);
    expect_val("nt2_target", P0_TARGET, 64'h204);
    settle();

    // Lower saturation: counter pinned at 0, one taken brings it to 1 only
    for (int i = 0; i < 3; i++) begin
      resolve0(64'h200, 1'b0, 1'b0, 64'h180, 1'b0, 64'h204);
      expect_val("sat_low_mis", P0_MIS, 0);
      cycle();
    end
    resolve0(64'h200, 1'b0, 1'b1, 64'h180, 1'b0, 64'h204);
    cycle();
    idle_update();
    expect_val("sat_low_taken", P0_TAKEN, 0);
    expect_val("sat_low_target", P0_TARGET, 64'h204);
    settle();

    // jal at 0x300 -> 0x1000 (shares BTB slot 0 with 0x200)
    resolve0(64'h300, 1'b1, 1'b1, 64'h1000, 1'b0, 64'h304);
    expect_val("jal_mis", P0_MIS, 1);
    expect_val("jal_redirect", P0_REDIR, 64'h1000);
    cycle();
    idle_update();
    drive_lookup(1'b1, 64'h300);
    expect_val("jal_taken", P0_TAKEN, 1);
    expect_val("jal_target", P0_TARGET, 64'h1000);
    settle();
    drive_lookup(1'b1, 64'h200);
    expect_val("alias_taken", P0_TAKEN, 0);
    expect_val("alias_target", P0_TARGET, 64'h204);
    settle();
    resolve0(64'h300, 1'b1, 1'b1, 64'h1000, 1'b1, 64'h1000);
    expect_val("jal_ok_mis", P0_MIS, 0);
    cycle();

    // Same-cycle lookup and update of 0x200
    drive_lookup(1'b1, 64'h200);
    resolve0(64'h200, 1'b0, 1'b1, 64'h180, 1'b0, 64'h204);
    expect_val("same_old_taken", P0_TAKEN, 0);
    expect_val("same_old_target", P0_TARGET, 64'h204);
    settle();
    expect_val("same_mis", P0_MIS, 1);
    expect_val("same_redirect", P0_REDIR, 64'h180);
    cycle();
    idle_update();
    expect_val("same_new_taken", P0_TAKEN, 1);
    expect_val("same_new_target", P0_TARGET, 64'h180);
    settle();

    // Reset overriding a mispredicting resolution
    resolve0(64'h200, 1'b0, 1'b0, 64'h180, 1'b1, 64'h180);
    rst = 1'b1;
    expect_val("rst_pend_mis", P0_MIS, 0);
    expect_val("rst_pend_redirect", P0_REDIR, 0);
    cycle();
    rst = 1'b0;
    idle_update();
    expect_val("rst_clr_taken", P0_TAKEN, 0);
    expect_val("rst_clr_target", P0_TARGET, 64'h204);
    settle();
    resolve0(64'h200, 1'b0, 1'b1, 64'h180, 1'b0, 64'h204);
    cycle();
    resolve0(64'h200, 1'b0, 1'b0, 64'h180, 1'b1, 64'h180);
    cycle();
    idle_update();
    expect_val("cnt_reset_taken", P0_TAKEN, 0);
    expect_val("cnt_reset_target", P0_TARGET, 64'h204);
    settle();

    // gshare: branch at 0x400 alternating T/N, target 0x480
    rst = 1'b1;
    drive_lookup(1'b0, '0);
    cycle();
    cycle();
    rst = 1'b0;
    for (int it = 1; it <= 24; it++) begin
      it_tk = (it % 2) == 1;
      idle_update();
      drive_lookup(1'b1, 64'h400);
      #1;
      cap_idx = p1_idx;
      cap_ghr = p1_ghr;
      cap_tk  = p1_taken;
      cap_tgt = p1_target;
      if (it > 8) begin
        expect_val("gs_idx", P1_IDX, it_tk ? 64'd42 : 64'd21);
        expect_val("gs_taken", P1_TAKEN, XLEN'(it_tk));
        expect_val("gs_target", P1_TARGET, it_tk ? 64'h480 : 64'h404);
        check_output();
      end
      cycle();
      drive_lookup(1'b0, '0);
      drive_update(1'b1, 64'h400, 1'b1, 1'b0, it_tk, 64'h480, cap_tk, cap_tgt, cap_idx, cap_ghr);
      if (it == 1)
        expect_val("gs_cold_mis", P1_MIS, 1);
      else if (it > 8)
        expect_val("gs_steady_mis", P1_MIS, 0);
      cycle();
    end

    // Forced mispredict: repair beats the speculative shift on the same edge
    drive_lookup(1'b1, 64'h400);
    drive_update(1'b1, 64'h400, 1'b1, 1'b0, 1'b1, 64'h480, 1'b0, 64'h404, 6'd42, 6'd45);
    expect_val("gs_force_mis", P1_MIS, 1);
    expect_val("gs_force_redirect", P1_REDIR, 64'h480);
    cycle();
    drive_lookup(1'b0, '0);
    idle_update();
    expect_val("ghr_repair", P1_GHR, 64'd27);
    expect_val("bimodal_ghr", P0_GHR, 0);
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv_bpu.md
Name: rv_bpu

Overview:
- Parametrised branch prediction unit for the rv pipeline; the next generation of the single-bit, 4-entry predictor.
- Provides a direct-mapped BTB plus a BHT of saturating counters. The BHT runs in bimodal or gshare mode.
- Lookup is same-cycle from the IF-stage PC. Update, allocation and mispredict detection are driven by the resolved branch/jump in EX.
- The unit also produces a registered redirect for the PC mux.

Parameters:
XLEN, 64, address/PC width
IDX_W, 6, log2 of BHT/BTB entries (64 entries)
CNT_W, 2, BHT saturating counter width (>=1)
TAG_W, 8, BTB tag width
MODE, 0, 0 = bimodal, 1 = gshare (BHT index XORed with GHR; GHR width = IDX_W)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
if_valid_i  in  1  IF lookup valid
if_stall_i  in  1  IF stalled; no speculative GHR update
if_pc_i  in  XLEN  fetch PC
pred_taken_o  out  1  predicted taken
pred_target_o  out  XLEN  predicted next PC
pred_idx_o  out  IDX_W  BHT index used; piped to EX
pred_ghr_o  out  IDX_W  GHR value at lookup; piped to EX
upd_valid_i  in  1  EX resolution valid
upd_pc_i  in  XLEN  PC of the resolved instruction
upd_idx_i  in  IDX_W  piped pred_idx_o
upd_ghr_i  in  IDX_W  piped pred_ghr_o
upd_is_br_i  in  1  conditional branch
upd_is_jmp_i  in  1  jal/jalr
upd_taken_i  in  1  actual outcome (1 for jumps)
upd_target_i  in  XLEN  actual target
upd_pred_taken_i  in  1  piped pred_taken_o
upd_pred_target_i  in  XLEN  piped pred_target_o
mispredict_o  out  1  one-cycle flush pulse
redirect_pc_o  out  XLEN  correct next PC, valid with mispredict_o

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, and overrides every other event on the same edge.
- Reset values:
  - all BTB valid bits 0
  - all counters = 2^(CNT_W-1)-1 (weakly not-taken)
  - GHR 0
  - mispredict_o 0
  - redirect_pc_o 0
- Indexing:
  - bidx = pc[IDX_W+1:2]
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2]
  - BHT index = bidx when MODE=0; bidx ^ GHR when MODE=1
- Lookup is combinational, zero latency:
  - hit = btb_valid[bidx] & tag match
  - pred_taken_o = hit & (btb_jmp[bidx] | cnt[MSB])
  - pred_target_o = pred_taken_o ? btb_target[bidx] : if_pc_i+4
  - pred_idx_o and pred_ghr_o show the current index and GHR.
  - Lookup reads pre-edge table state. An update to the same entry in the same cycle is not visible until the next cycle.
- Speculative GHR (MODE=1 only): on if_valid_i & !if_stall_i & hit & !btb_jmp[bidx], GHR <= {GHR[IDX_W-2:0], pred_taken_o}.
- Update, applied at the edge where upd_valid_i=1:
  - Counter: if upd_is_br_i, cnt[upd_idx_i] increments when taken and decrements when not taken. It saturates at 0 and at 2^CNT_W-1 with no wrap.
  - BTB allocation: if (upd_is_br_i & upd_taken_i) | upd_is_jmp_i, write entry at upd bidx with valid=1, tag, target=upd_target_i, jmp=upd_is_jmp_i. This overwrites any prior entry.
  - Not-taken branches never allocate and never invalidate.
- Mispredict detection:
  - actual = upd_taken_i ? upd_target_i : upd_pc_i+4
  - predicted = upd_pred_taken_i ? upd_pred_target_i : upd_pc_i+4
  - mis = upd_valid_i & (actual != predicted)
  - Registered: mispredict_o=1 and redirect_pc_o=actual on the cycle after upd_valid_i. mispredict_o returns to 0 otherwise. redirect_pc_o holds its last value.
- GHR repair: when mis=1, GHR <= upd_is_br_i ? {upd_ghr_i[IDX_W-2:0], upd_taken_i} : upd_ghr_i. Repair wins over a speculative shift on the same edge.
- GHR in MODE=0: held at 0.
- upd_is_br_i and upd_is_jmp_i both 1 is illegal. The bench asserts it never occurs.
- Arithmetic: PC+4 wraps modulo 2^XLEN.

Test Plan:
- Reset: apply rst for 2 cycles, then look up any PC (e.g. 0x100) -> pred_taken_o=0, pred_target_o=0x104, mispredict_o=0.
- Cold taken branch at 0x200 with target 0x180:
  - first resolution (pred 0/0x204) -> mispredict_o=1, redirect_pc_o=0x180 next cycle.
  - next lookup of 0x200 -> hit, cnt=2, pred_taken_o=1, pred_target_o=0x180.
- Saturation (CNT_W=2): resolve 0x200 as taken 5 times -> cnt stays 3. Then 1 not-taken -> cnt=2 and lookup still predicts taken. Second not-taken -> cnt=1, predicts 0x204.
- jal at 0x300 with target 0x1000: after one resolution, lookup -> taken to 0x1000 regardless of counter. Re-resolution with matching prediction -> mispredict_o stays 0.
- Same-cycle lookup and update of 0x200: lookup returns old prediction, next cycle returns new. Assert rst during a pending mispredict -> mispredict_o=0 and tables cleared.
- MODE=1 with a branch alternating T/N at 0x400:
  - after warm-up, two distinct BHT indices are used and the mispredict rate reaches 0 over 16 iterations.
  - forcing a mispredict -> GHR equals {upd_ghr_i[4:0], upd_taken_i}.
